// File: rtl/ntt_butterfly.sv
// Pipelined radix-2 NTT butterfly with one shared Barrett multiplier.
// Supports forward Cooley-Tukey (mode 0) and inverse Gentleman-Sande (mode 1)
// per transaction. It has three stages under a global stall, and each stage
// carries its own modulus.

// Combinational Barrett reduction of a*b mod q, where mu = floor(2^64 / q).
// When a, b < q < 2^32, the product fits in 64 bits. The quotient estimate
// is then short by at most 2, so two conditional subtractions finish the job.
module mod_mult (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [63:0] q,
  input  logic [63:0] mu,
  output logic [63:0] out
);
  logic [63:0] x;
  logic [63:0] qhat;
  logic [63:0] r0;
  logic [63:0] r1;

  assign x    = a * b;
  assign qhat = 64'((128'(x) * 128'(mu)) >> 64);
  assign r0   = x - qhat * q;
  assign r1   = (r0 >= q) ? r0 - q : r0;
  assign out  = (r1 >= q) ? r1 - q : r1;
endmodule

module ntt_butterfly #(
  parameter int TAG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [63:0]      in_w,
  input  logic [63:0]      in_q,
  input  logic [63:0]      in_mu,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_a,
  output logic [63:0]      out_b,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  // (x + y) mod q, with a 65-bit intermediate sum so that carry-out is kept
  function automatic logic [63:0] mod_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic [63:0] q);
    logic [64:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= {1'b0, q}) ? 64'(s - {1'b0, q}) : s[63:0];
  endfunction

  // (x - y) mod q, with a single correction
  function automatic logic [63:0] mod_sub(input logic [63:0] x, input logic [63:0] y,
                                          input logic [63:0] q);
    return (x >= y) ? x - y : x - y + q;
  endfunction

  // Stage 1 registers
  logic             v1_reg;
  logic [63:0]      a1_reg, b1_reg, w1_reg, q1_reg, mu1_reg;
  logic [63:0]      sum1_reg, diff1_reg;
  logic             mode1_reg;
  logic [TAG_W-1:0] tag1_reg;

  // Stage 2 registers
  logic             v2_reg;
  logic [63:0]      p2_reg, x2_reg, q2_reg;
  logic             mode2_reg;
  logic [TAG_W-1:0] tag2_reg;

  // Stage 3 (output) registers
  logic             v3_reg;
  logic [63:0]      out_a_reg, out_b_reg;
  logic [TAG_W-1:0] tag3_reg;

  logic             advance;
  logic             accept;
  logic [63:0]      mult_a;
  logic [63:0]      mult_out;

  // The whole pipe moves only when the output slot is empty or draining.
  // As a result, in_ready depends combinationally on out_ready.
  assign advance  = !v3_reg || out_ready;
  assign in_ready = advance && !rst;
  assign accept   = in_valid && in_ready;

  // CT multiplies b by w. GS multiplies the stage-1 difference by w.
  assign mult_a = mode1_reg ? diff1_reg : b1_reg;

  mod_mult u_mod_mult (
    .a   (mult_a),
    .b   (w1_reg),
    .q   (q1_reg),
    .mu  (mu1_reg),
    .out (mult_out)
  );

  assign out_valid = v3_reg;
  assign out_a     = out_a_reg;
  assign out_b     = out_b_reg;
  assign out_tag   = tag3_reg;
  assign busy      = v1_reg || v2_reg || v3_reg;

  // Three-stage pipeline: reset clears everything, and a stall freezes all stages together
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg    <= 1'b0;
      a1_reg    <= '0;
      b1_reg    <= '0;
      w1_reg    <= '0;
      q1_reg    <= '0;
      mu1_reg   <= '0;
      sum1_reg  <= '0;
      diff1_reg <= '0;
      mode1_reg <= 1'b0;
      tag1_reg  <= '0;
      v2_reg    <= 1'b0;
      p2_reg    <= '0;
      x2_reg    <= '0;
      q2_reg    <= '0;
      mode2_reg <= 1'b0;
      tag2_reg  <= '0;
      v3_reg    <= 1'b0;
      out_a_reg <= '0;
      out_b_reg <= '0;
      tag3_reg  <= '0;
    end else if (advance) begin
      v1_reg <= accept;
      if (accept) begin
        a1_reg    <= in_a;
        b1_reg    <= in_b;
        w1_reg    <= in_w;
        q1_reg    <= in_q;
        mu1_reg   <= in_mu;
        mode1_reg <= in_mode;
        tag1_reg  <= in_tag;
        sum1_reg  <= in_mode ? mod_add(in_a, in_b, in_q) : '0;
        diff1_reg <= in_mode ? mod_sub(in_a, in_b, in_q) : '0;
      end

      v2_reg    <= v1_reg;
      p2_reg    <= mult_out;
      x2_reg    <= mode1_reg ? sum1_reg : a1_reg;
      q2_reg    <= q1_reg;
      mode2_reg <= mode1_reg;
      tag2_reg  <= tag1_reg;

      v3_reg    <= v2_reg;
      out_a_reg <= mode2_reg ? x2_reg : mod_add(x2_reg, p2_reg, q2_reg);
      out_b_reg <= mode2_reg ? p2_reg : mod_sub(x2_reg, p2_reg, q2_reg);
      tag3_reg  <= tag2_reg;
    end
  end

endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly: a queue-based reference model plus directed literal cases.
module tb_ntt_butterfly;
  localparam logic [63:0] Q17   = 64'd17;
  localparam logic [63:0] MU17  = 64'd1085102592571150095;
  localparam logic [63:0] QBIG  = 64'd4294967291;
  localparam logic [63:0] MUBIG = 64'd4294967301;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_mode = 1'b0;
  logic [63:0] in_a = '0, in_b = '0, in_w = '0, in_q = Q17, in_mu = MU17;
  logic [15:0] in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_a, out_b;
  logic [15:0] out_tag;
  logic        busy;

  ntt_butterfly #(.TAG_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_q(in_q), .in_mu(in_mu), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [15:0] tag;
    int          cyc;
    bit          seen;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] emitted_tags[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_stall = -1;
  bit          rst_prev = 1'b0;
  bit          stall_prev = 1'b0;
  bit          busy_chk = 1'b0;
  bit          rand_ready = 1'b0;
  logic [63:0] prev_a, prev_b;
  logic [15:0] prev_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // The butterfly computed directly from the modular-arithmetic definitions
  function automatic void model(input logic mode, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] w, input logic [63:0] q,
                                output logic [63:0] ea, output logic [63:0] eb);
    logic [127:0] ra, rb, rw, rq, t, d;
    ra = 128'(a); rb = 128'(b); rw = 128'(w); rq = 128'(q);
    if (!mode) begin
      t  = (rb * rw) % rq;
      ea = 64'((ra + t) % rq);
      eb = 64'((ra + rq - t) % rq);
    end else begin
      ea = 64'((ra + rb) % rq);
      d  = (ra + rq - rb) % rq;
      eb = 64'((d * rw) % rq);
    end
  endfunction

  // Monitor: samples mid-cycle, tracks accepts/emits and checks every meaningful cycle
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      if (rst_prev) begin
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_a", out_a, 64'd0);
        chk("rst_out_b", out_b, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
      end
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      exp_q.delete();
      stall_prev = 1'b0;
      busy_chk = 1'b0;
    end else begin
      chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (busy_chk) chk("busy_falls", 64'(busy), 64'd0);
      busy_chk = 1'b0;
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_a", out_a, prev_a);
        chk("stall_b", out_b, prev_b);
        chk("stall_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (exp_q.size() == 3) chk("full_pipe_valid", 64'(out_valid), 64'd1);
      if (exp_q.size() > 3) chk("inflight_le_3", 64'(exp_q.size()), 64'd3);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q[0];
          chk("out_a", out_a, e.a);
          chk("out_b", out_b, e.b);
          chk("out_tag", 64'(out_tag), 64'(e.tag));
          if (!e.seen) begin
            if (last_stall < e.cyc) chk("latency", 64'(cyc - e.cyc), 64'd3);
            exp_q[0].seen = 1'b1;
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            emitted_tags.push_back(out_tag);
            if (exp_q.size() == 0 && !(in_valid && in_ready)) busy_chk = 1'b1;
          end
        end
        if (!out_ready) last_stall = cyc;
      end
      stall_prev = out_valid && !out_ready;
      prev_a = out_a; prev_b = out_b; prev_tag = out_tag;
      if (in_valid && in_ready) begin
        model(in_mode, in_a, in_b, in_w, in_q, e.a, e.b);
        e.tag = in_tag; e.cyc = cyc; e.seen = 1'b0;
        exp_q.push_back(e);
      end
    end
    rst_prev = rst;
  end

  // Random backpressure during the streaming phase
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic m, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] w, input logic [63:0] q, input logic [63:0] mu,
                      input logic [15:0] tag);
    bit acc = 1'b0;
    in_mode = m; in_a = a; in_b = b; in_w = w; in_q = q; in_mu = mu; in_tag = tag;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic expect_result(input string name, input logic [63:0] ea, input logic [63:0] eb);
    bit got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        chk({name, "_a"}, out_a, ea);
        chk({name, "_b"}, out_b, eb);
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_random(input int i);
    logic [63:0] q, mu;
    q  = (i % 2 == 1) ? QBIG : Q17;
    mu = (i % 2 == 1) ? MUBIG : MU17;
    send(1'($urandom_range(0, 1)), 64'($urandom) % q, 64'($urandom) % q, 64'($urandom) % q,
         q, mu, 16'($urandom));
  endtask

  initial begin
    int acc_cnt;
    bit acc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed cases with hand-computed results
    send(1'b0, 64'd5, 64'd3, 64'd4, Q17, MU17, 16'h00a1);
    expect_result("ct_basic", 64'd0, 64'd10);
    send(1'b1, 64'd5, 64'd3, 64'd4, Q17, MU17, 16'h00a2);
    expect_result("gs_basic", 64'd8, 64'd8);
    send(1'b0, QBIG - 1, QBIG - 1, QBIG - 1, QBIG, MUBIG, 16'h00a3);
    expect_result("ct_wrap", 64'd0, 64'd4294967289);
    wait_drain();

    // Backpressure: only three fit while out_ready is low
    @(posedge clk); #1;
    emitted_tags.delete();
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int t = 1; t <= 4; t++) begin
      in_valid = 1'b1; in_mode = 1'b0; in_q = Q17; in_mu = MU17;
      in_a = 64'(t); in_b = 64'(t + 5); in_w = 64'(t + 9); in_tag = 16'(t);
      @(negedge clk);
      if (in_ready) acc_cnt++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", 64'(acc_cnt), 64'd3);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_tag", 64'(out_tag), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_tag4_accepted", 64'(acc), 64'd1);
    wait_drain();
    chk("bp_drain_count", 64'(emitted_tags.size()), 64'd4);
    for (int i = 0; i < emitted_tags.size() && i < 4; i++)
      chk("bp_drain_order", 64'(emitted_tags[i]), 64'(i + 1));

    // Streaming with mixed moduli and random backpressure
    @(posedge clk); #1;
    rand_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send_random(i);
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain();

    // Reset with two transactions in flight
    @(posedge clk); #1;
    send_random(0);
    send_random(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(1'b0, 64'd10, 64'd7, 64'd9, Q17, MU17, 16'h00b1);
    expect_result("post_rst_ct", 64'd5, 64'd15);
    wait_drain();
    @(negedge clk);
    chk("final_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
